// File: rtl/rgb_pkg.sv
// Shared constants for the rainbow breathing lamp path: hue colour enables,
// hue/speed counts and the brightness ramp state encoding.
package rgb_pkg;

  localparam logic [2:0] HUE_R = 3'b100;
  localparam logic [2:0] HUE_Y = 3'b110;
  localparam logic [2:0] HUE_G = 3'b010;
  localparam logic [2:0] HUE_C = 3'b011;
  localparam logic [2:0] HUE_B = 3'b001;
  localparam logic [2:0] HUE_M = 3'b101;

  localparam int NUM_HUE = 6;
  localparam int NUM_SPD = 4;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } bri_state_e;

  // {R,G,B} enables for a hue segment; out-of-range segments stay dark.
  function automatic logic [2:0] hue_en(input logic [2:0] seg);
    case (seg)
      3'd0:    hue_en = HUE_R;
      3'd1:    hue_en = HUE_Y;
      3'd2:    hue_en = HUE_G;
      3'd3:    hue_en = HUE_C;
      3'd4:    hue_en = HUE_B;
      3'd5:    hue_en = HUE_M;
      default: hue_en = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/pwm_chan.sv
// One PWM colour channel: duty is captured on the shared latch strobe and
// compared against the shared counter into a registered output bit.
module pwm_chan
  import rgb_pkg::*;
#(
  parameter int PWM_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [PWM_W-1:0] pwm_cnt,
  input  logic [PWM_W-1:0] duty,
  input  logic             latch,
  output logic             pwm_o
);

  logic [PWM_W-1:0] duty_q, duty_d;
  logic             out_q, out_d;

  always_comb begin
    duty_d = duty_q;
    if (latch) begin
      duty_d = duty;
    end else begin
      duty_d = duty_q;
    end
    out_d = (pwm_cnt < duty_q);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      duty_q <= '0;
      out_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      out_q  <= out_d;
    end
  end

  assign pwm_o = out_q;

endmodule

// File: rtl/breath_rgb.sv
// Rainbow breathing generator: key presses select speed and single/dual lamp
// mode; brightness ramps up and down while the hue steps once per breath.
module breath_rgb
  import rgb_pkg::*;
#(
  parameter int PWM_W    = 8,
  parameter int STEP_DIV = 24414
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       KP_SPD,
  input  logic       KP_MODE,
  output logic [2:0] LED1,
  output logic [2:0] LED2
);

  localparam logic [PWM_W-1:0] MAX = {PWM_W{1'b1}};
  // One spare bit so the slowest terminal count never aliases.
  localparam int DIV_W = $clog2(STEP_DIV << (NUM_SPD - 1)) + 1;
  localparam logic [DIV_W-1:0] DIV_BASE = DIV_W'(STEP_DIV);

  logic [1:0]       kp_q, kp_d;
  logic [1:0]       spd_q, spd_d;
  logic             mode_q, mode_d;
  logic [DIV_W-1:0] div_q, div_d;
  bri_state_e       state_q, state_d;
  logic [PWM_W-1:0] bri_q, bri_d;
  logic [2:0]       hue_q, hue_d;
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;

  logic             press_spd_s, press_mode_s, step_s, latch_s;
  logic [DIV_W-1:0] div_max_s;
  logic [2:0]       hue_en_s, led1_s;
  logic [PWM_W-1:0] duty_r_s, duty_g_s, duty_b_s;

  always_comb begin
    kp_d         = {KP_MODE, KP_SPD};
    press_spd_s  = kp_q[0] & ~KP_SPD;
    press_mode_s = kp_q[1] & ~KP_MODE;
    spd_d        = spd_q + {1'b0, press_spd_s};
    mode_d       = mode_q ^ press_mode_s;
    div_max_s    = (DIV_BASE << spd_q) - DIV_W'(1);
    step_s       = (div_q == div_max_s);
    // A speed change restarts the period, but a step already due still lands.
    if (step_s || press_spd_s) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
    pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
    latch_s   = (pwm_cnt_q == MAX);
  end

  always_comb begin
    state_d = state_q;
    bri_d   = bri_q;
    hue_d   = hue_q;
    if (step_s) begin
      case (state_q)
        UP: begin
          bri_d = bri_q + PWM_W'(1);
          if (bri_d == MAX) begin
            state_d = DOWN;
          end else begin
            state_d = UP;
          end
        end
        DOWN: begin
          bri_d = bri_q - PWM_W'(1);
          if (bri_q == PWM_W'(1)) begin
            state_d = UP;
            hue_d   = (hue_q == 3'(NUM_HUE - 1)) ? 3'd0 : hue_q + 3'd1;
          end else begin
            state_d = DOWN;
          end
        end
        default: begin
          state_d = UP;
          bri_d   = '0;
        end
      endcase
    end else begin
      state_d = state_q;
      bri_d   = bri_q;
      hue_d   = hue_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      kp_q      <= 2'b11;
      spd_q     <= 2'd0;
      mode_q    <= 1'b0;
      div_q     <= '0;
      state_q   <= UP;
      bri_q     <= '0;
      hue_q     <= 3'd0;
      pwm_cnt_q <= '0;
    end else begin
      kp_q      <= kp_d;
      spd_q     <= spd_d;
      mode_q    <= mode_d;
      div_q     <= div_d;
      state_q   <= state_d;
      bri_q     <= bri_d;
      hue_q     <= hue_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  always_comb begin
    hue_en_s = hue_en(hue_q);
    duty_r_s = hue_en_s[2] ? bri_q : '0;
    duty_g_s = hue_en_s[1] ? bri_q : '0;
    duty_b_s = hue_en_s[0] ? bri_q : '0;
  end

  pwm_chan #(.PWM_W(PWM_W)) u_r (
    .CLK(CLK), .RST(RST), .pwm_cnt(pwm_cnt_q), .duty(duty_r_s), .latch(latch_s), .pwm_o(led1_s[2])
  );
  pwm_chan #(.PWM_W(PWM_W)) u_g (
    .CLK(CLK), .RST(RST), .pwm_cnt(pwm_cnt_q), .duty(duty_g_s), .latch(latch_s), .pwm_o(led1_s[1])
  );
  pwm_chan #(.PWM_W(PWM_W)) u_b (
    .CLK(CLK), .RST(RST), .pwm_cnt(pwm_cnt_q), .duty(duty_b_s), .latch(latch_s), .pwm_o(led1_s[0])
  );

  // Lamp 2 mirrors lamp 1 straight from its flops so the two never skew.
  assign LED1 = led1_s;
  assign LED2 = mode_q ? led1_s : 3'b000;

endmodule

// File: doc/breath_rgb.md
# breath_rgb

Rainbow breathing generator for the RGB lamp path. Consumes the two debounced key levels produced by the key debouncer, turns key presses into a breathing-speed index and a single/dual-lamp mode, and drives two RGB lamps. Each lamp gets a hue that steps through six colours once per breath, with PWM brightness ramping 0→max→0.

## Interface
- PWM_W, 8: brightness and PWM counter width; MAX = 2^PWM_W − 1.
- STEP_DIV, 24414: clock cycles per brightness step at speed 0 (≈0.49 ms at 50 MHz).
- CLK  in  1  system clock; the only clock.
- RST  in  1  reset, asynchronous, active-high.
- KP_SPD  in  1  debounced speed key level; 1 = released, 0 = pressed.
- KP_MODE  in  1  debounced mode key level; same polarity.
- LED1  out  3  lamp 1 {R,G,B}, active-high PWM.
- LED2  out  3  lamp 2 {R,G,B}, active-high PWM.

## Operation
- **Press detect.**
  - kp_q registers each key level; reset value 1.
  - press = kp_q & ~KP, one cycle per falling edge.
  - Holding a key low produces no further presses.
- **Speed.**
  - spd is 2 bits, reset 0.
  - A KP_SPD press increments spd, wrapping 3→0.
- **Mode.**
  - mode is 1 bit, reset 0; a KP_MODE press toggles it.
  - Mode 0: LED2 = 000.
  - Mode 1: LED2 = LED1 every cycle.
- **Step divider.**
  - div_cnt counts 0..(STEP_DIV << spd) − 1.
  - step pulses for one cycle at the terminal count, then div_cnt returns to 0.
  - A speed press clears div_cnt in the same cycle that spd updates. A step pulse already asserted that cycle is still applied.
- **Brightness FSM.**
  - States UP and DOWN; reset state UP with bri = 0.
  - UP on step: bri ← bri+1; if bri+1 == MAX, go to DOWN.
  - DOWN on step: bri ← bri−1; if bri−1 == 0, go to UP and advance hue.
  - One full breath is 2·MAX steps. bri never leaves 0..MAX.
- **Hue.**
  - 3-bit segment, reset 0, advances 0..5 and wraps 5→0.
  - Colour enables {R,G,B}: 0 = 100, 1 = 110, 2 = 010, 3 = 011, 4 = 001, 5 = 101.
- **PWM.**
  - pwm_cnt is a free-running PWM_W-bit counter, reset 0.
  - Each channel latches duty = (enable ? bri : 0) when pwm_cnt == MAX.
  - Channel output, registered: out = (pwm_cnt < duty_latched).
  - Duty 0 gives a constant 0; duty MAX gives MAX of every 2^PWM_W cycles high.
- **Simultaneous events.**
  - Both keys pressed in one cycle: both actions take effect.
  - A step coinciding with a hue wrap or a PWM latch is applied normally. The latch samples the pre-step bri.

## Timing
- **Reset values:**
  - LED1 = LED2 = 000.
  - spd 0, mode 0, bri 0, state UP, hue 0.
  - div_cnt 0, pwm_cnt 0, all latched duties 0, kp_q 1.
- **Reset is asynchronous.** Asserting RST mid-operation forces the outputs to 000 without waiting for a clock edge. The first step after release occurs STEP_DIV cycles later.
- **Key latency.** spd/mode change at the first CLK edge that samples KP = 0 after KP = 1.
- **Brightness latency.** A new bri reaches the outputs after the next pwm_cnt == MAX latch plus one output register. Worst case is 2^PWM_W + 1 cycles.
- **Step period.** Exactly STEP_DIV << spd cycles between step pulses in steady state.

## Structure
- **Package rgb_pkg:**
  - hue enable constants HUE_R, HUE_Y, HUE_G, HUE_C, HUE_B, HUE_M (3-bit);
  - NUM_HUE = 6;
  - NUM_SPD = 4;
  - brightness state encoding (UP = 0, DOWN = 1).
- **Sub-module pwm_chan.** Inputs: CLK, RST, shared pwm_cnt, duty, latch strobe. Output: one registered PWM bit. Instantiated three times; LED2 is derived from LED1 and mode.
- Press detection, the divider, the FSM and hue stay in breath_rgb.

## Test plan
Use PWM_W = 4 and STEP_DIV = 4 unless stated.
- **Reset:** assert RST mid-breath between edges → LED1 = LED2 = 000 immediately; after release, bri = 0, hue = 0, spd = 0, mode = 0.
- **Speed:** hold KP_SPD low for 100 cycles → spd 0→1 once only. Three more presses → 2, 3, 0. Measured step periods are 4, 8, 16, 32 cycles.
- **Breath/hue:**
  - Ramp: bri goes 0→15 in 15 steps (60 cycles), then 15→0.
  - At bri = 0, hue becomes 1: LED1 R and G both pulse, B stays 0.
  - After 6 breaths hue is back to 0.
- **PWM duty:** once bri = 8 is latched, LED1[R] is high for exactly 8 of 16 cycles. With bri = 0, it stays low for a full period.
- **Mode:** in mode 0, LED2 = 000 throughout. One KP_MODE press → LED2 == LED1 on every cycle. A second press → 000 again.
- **Simultaneous:** KP_SPD and KP_MODE fall on the same edge → spd and mode both update that edge, and div_cnt is 0 on the next cycle.
